// File: rtl/controlador_memoria.sv
// controlador_memoria: single-port RAM shared by an instruction-fetch port and a data port.
// Ack LATENCY+1 cycles after grant, one access in flight; requesters hold req until their ack.
module controlador_memoria #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    typedef struct packed {
        logic                  port_dm;
        logic                  we;
        logic                  misaligned;
        logic [DEPTH_LOG2-1:0] idx;
        logic [31:0]           wdata;
    } acc_t;

    logic [31:0] mem [WORDS];

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic       last_dm;
    logic       grant_dm;
    acc_t       acc;
    acc_t       acc_next;
    logic       wait_last;
    logic       do_write;

    // Upper address bits alias onto the RAM; fetch ignores the byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:DEPTH_LOG2+2], if_addr[1:0],
                                dm_addr[31:DEPTH_LOG2+2]};

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_dm = 1'b0;
        if (dm_req && if_req) begin
            grant_dm = !last_dm;
        end else begin
            grant_dm = dm_req;
        end
    end

    always_comb begin
        acc_next = '0;
        acc_next.port_dm = grant_dm;
        if (grant_dm) begin
            acc_next.we         = dm_we;
            acc_next.misaligned = |dm_addr[1:0];
            acc_next.idx        = dm_addr[DEPTH_LOG2+1:2];
            acc_next.wdata      = dm_wdata;
        end else begin
            acc_next.idx = if_addr[DEPTH_LOG2+1:2];
        end
    end

    assign wait_last = (state == ST_WAIT) && (wait_cnt == 4'd0);
    assign do_write  = !reset && (state == ST_DONE) && acc.port_dm && acc.we
                       && !acc.misaligned;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            last_dm  <= 1'b0;
            acc      <= '0;
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        acc      <= acc_next;
                        last_dm  <= grant_dm;
                        wait_cnt <= WAIT_LOAD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_last) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Read data lands on the edge entering DONE so it is valid alongside ack.
            if (wait_last) begin
                if (acc.port_dm) begin
                    if (acc.misaligned) begin
                        dm_rdata <= 32'd0;
                    end else if (!acc.we) begin
                        dm_rdata <= mem[acc.idx];
                    end
                end else begin
                    if_rdata <= mem[acc.idx];
                end
            end
        end
    end

    // RAM array is intentionally not reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[acc.idx] <= acc.wdata;
        end
    end

    assign if_ack = (state == ST_DONE) && !acc.port_dm;
    assign dm_ack = (state == ST_DONE) && acc.port_dm;
    assign dm_err = dm_ack && acc.misaligned;
    assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_controlador_memoria.sv
// Scoreboard bench for controlador_memoria: stimulus pushes expected acks, negedge monitors pop and compare.
module tb_controlador_memoria;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        dm_err;
    logic        busy;

    logic        a1_req;
    logic        a4_req;
    logic [31:0] a1_unused_if_rdata, a4_unused_if_rdata;
    logic [31:0] a1_unused_dm_rdata, a4_unused_dm_rdata;
    logic        a1_unused_if_ack, a4_unused_if_ack;
    logic        a1_unused_dm_err, a4_unused_dm_err;
    logic        a1_dm_ack, a4_dm_ack;
    logic        a1_busy, a4_busy;

    controlador_memoria #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err), .busy(busy)
    );

    controlador_memoria #(.DEPTH_LOG2(8), .LATENCY(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(32'd0), .if_rdata(a1_unused_if_rdata), .if_ack(a1_unused_if_ack),
        .dm_req(a1_req), .dm_we(1'b0), .dm_addr(32'h0000_0040), .dm_wdata(32'd0),
        .dm_rdata(a1_unused_dm_rdata), .dm_ack(a1_dm_ack), .dm_err(a1_unused_dm_err), .busy(a1_busy)
    );

    controlador_memoria #(.DEPTH_LOG2(8), .LATENCY(4)) dut_l4 (
        .clock(clock), .reset(reset),
        .if_req(1'b0), .if_addr(32'd0), .if_rdata(a4_unused_if_rdata), .if_ack(a4_unused_if_ack),
        .dm_req(a4_req), .dm_we(1'b0), .dm_addr(32'h0000_0040), .dm_wdata(32'd0),
        .dm_rdata(a4_unused_dm_rdata), .dm_ack(a4_dm_ack), .dm_err(a4_unused_dm_err), .busy(a4_busy)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t q_if[$];
    exp_t q_dm[$];
    int   q_a1[$];
    int   q_a4[$];

    int cyc  = 0;
    int nvec = 0;
    int nmis = 0;
    int a1_busy_n = 0;
    int a4_busy_n = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endfunction

    function automatic void unexpected(input string name);
        nvec++;
        nmis++;
        $display("FAIL %s: ack with nothing outstanding at cycle %0d", name, cyc);
    endfunction

    // Main-instance monitor
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("dm_err_without_ack", 32'(dm_err & ~dm_ack), 32'd0);
            if (dm_ack) begin
                if (q_dm.size() == 0) begin
                    unexpected("dm_ack");
                end else begin
                    e = q_dm.pop_front();
                    check("dm_ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("dm_err", 32'(dm_err), 32'(e.err));
                    if (e.chk) check("dm_rdata", dm_rdata, e.data);
                end
            end
            if (if_ack) begin
                if (q_if.size() == 0) begin
                    unexpected("if_ack");
                end else begin
                    e = q_if.pop_front();
                    check("if_ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk) check("if_rdata", if_rdata, e.data);
                end
            end
        end
    end

    // Latency-variant monitor: ack cycle and busy width
    always @(negedge clock) begin
        if (reset) begin
            a1_busy_n = 0;
            a4_busy_n = 0;
        end else begin
            if (a1_busy) a1_busy_n++;
            if (a4_busy) a4_busy_n++;
            if (a1_dm_ack) begin
                if (q_a1.size() == 0) unexpected("l1_ack");
                else check("l1_ack_cycle", 32'(cyc), 32'(q_a1.pop_front()));
                check("l1_busy_cycles", 32'(a1_busy_n), 32'd2);
                a1_busy_n = 0;
            end
            if (a4_dm_ack) begin
                if (q_a4.size() == 0) unexpected("l4_ack");
                else check("l4_ack_cycle", 32'(cyc), 32'(q_a4.pop_front()));
                check("l4_busy_cycles", 32'(a4_busy_n), 32'd5);
                a4_busy_n = 0;
            end
        end
    end

    // Issue fetch and/or data request (called just after a rising edge); lat = expected ack offset.
    task automatic run(input bit f_en, input logic [31:0] f_addr, input logic [31:0] f_exp,
                       input bit f_chk, input int f_lat,
                       input bit d_en, input bit d_we, input logic [31:0] d_addr,
                       input logic [31:0] d_wdata, input logic [31:0] d_exp, input bit d_chk,
                       input bit d_err, input int d_lat, input bit scramble);
        exp_t e;
        bit   got_f, got_d, drop_f, drop_d;
        int   n;
        if (f_en) begin
            e.data = f_exp; e.chk = f_chk; e.err = 1'b0; e.cyc = cyc + f_lat;
            q_if.push_back(e);
            if_req  = 1'b1;
            if_addr = f_addr;
        end
        if (d_en) begin
            e.data = d_exp; e.chk = d_chk; e.err = d_err; e.cyc = cyc + d_lat;
            q_dm.push_back(e);
            dm_req   = 1'b1;
            dm_we    = d_we;
            dm_addr  = d_addr;
            dm_wdata = d_wdata;
        end
        got_f = !f_en;
        got_d = !d_en;
        n = 0;
        while (!(got_f && got_d) && n < 64) begin
            @(negedge clock);
            n++;
            drop_f = if_ack && !got_f;
            drop_d = dm_ack && !got_d;
            @(posedge clock);
            #1;
            if (scramble && n == 1) begin
                dm_we    = ~dm_we;
                dm_addr  = 32'h0000_0000;
                dm_wdata = 32'h5555_5555;
            end
            if (drop_f) begin if_req = 1'b0; got_f = 1'b1; end
            if (drop_d) begin dm_req = 1'b0; dm_we = 1'b0; got_d = 1'b1; end
        end
        if (n >= 64) begin
            nvec++;
            nmis++;
            $display("FAIL run_timeout: got no ack after %0d cycles, expected ack", n);
        end
    endtask

    task automatic aux_issue();
        bit got1, got4, d1, d4;
        int n;
        q_a1.push_back(cyc + 2);
        q_a4.push_back(cyc + 5);
        a1_req = 1'b1;
        a4_req = 1'b1;
        got1 = 1'b0;
        got4 = 1'b0;
        n = 0;
        while (!(got1 && got4) && n < 64) begin
            @(negedge clock);
            n++;
            d1 = a1_dm_ack && !got1;
            d4 = a4_dm_ack && !got4;
            @(posedge clock);
            #1;
            if (d1) begin a1_req = 1'b0; got1 = 1'b1; end
            if (d4) begin a4_req = 1'b0; got4 = 1'b1; end
        end
        if (n >= 64) begin
            nvec++;
            nmis++;
            $display("FAIL aux_timeout: got no ack after %0d cycles, expected ack", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        a1_req = 1'b0; a4_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_dm_ack", 32'(dm_ack), 32'd0);
        check("rst_dm_err", 32'(dm_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);

        // Tie straight out of reset: data first (ack +3), fetch after (ack +7)
        @(posedge clock);
        #1;
        reset = 1'b0;
        run(1, 32'h104, 32'd0, 0, 7,  1, 0, 32'h100, 32'd0, 32'd0, 0, 0, 3, 0);

        // Write then fetch of the same word, fetch offset bits ignored
        run(0, 32'd0, 32'd0, 0, 0,  1, 1, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0, 3, 0);
        run(1, 32'h10, 32'hDEADBEEF, 1, 3,  0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        run(1, 32'h13, 32'hDEADBEEF, 1, 3,  0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h10, 32'd0, 32'hDEADBEEF, 1, 0, 3, 0);

        // Tie with data last granted: fetch first
        run(1, 32'h12, 32'hDEADBEEF, 1, 3,  1, 0, 32'h10, 32'd0, 32'hDEADBEEF, 1, 0, 7, 0);

        // Misaligned write rejected; misaligned read returns zero
        run(0, 32'd0, 32'd0, 0, 0,  1, 1, 32'h400, 32'h11112222, 32'hDEADBEEF, 1, 0, 3, 0);
        run(0, 32'd0, 32'd0, 0, 0,  1, 1, 32'h402, 32'h12345678, 32'd0, 1, 1, 3, 0);
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h400, 32'd0, 32'h11112222, 1, 0, 3, 0);
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h401, 32'd0, 32'd0, 1, 1, 3, 0);

        // Address aliasing above 1 KiB
        run(0, 32'd0, 32'd0, 0, 0,  1, 1, 32'h0, 32'hA5A5A5A5, 32'd0, 1, 0, 3, 0);
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h400, 32'd0, 32'hA5A5A5A5, 1, 0, 3, 0);
        run(1, 32'h800, 32'hA5A5A5A5, 1, 3,  0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);

        // Inputs changed during WAIT must be ignored (no write to word 0)
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h10, 32'd0, 32'hDEADBEEF, 1, 0, 3, 1);
        run(0, 32'd0, 32'd0, 0, 0,  1, 0, 32'h0, 32'd0, 32'hA5A5A5A5, 1, 0, 3, 0);

        // Reset during WAIT aborts a write
        run(0, 32'd0, 32'd0, 0, 0,  1, 1, 32'h20, 32'h0BADF00D, 32'hA5A5A5A5, 1, 0, 3, 0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hFFFF0000;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("abort_busy_in_wait", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        dm_req = 1'b0; dm_we = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dm_ack", 32'(dm_ack), 32'd0);
        check("abort_dm_rdata", dm_rdata, 32'd0);
        check("abort_if_rdata", if_rdata, 32'd0);
        @(posedge clock);
        #1;
        // Last-granted back to fetch after reset: data wins the tie
        run(1, 32'h0, 32'hA5A5A5A5, 1, 7,  1, 0, 32'h20, 32'd0, 32'h0BADF00D, 1, 0, 3, 0);

        // LATENCY=1 and LATENCY=4 instances, back to back
        aux_issue();
        aux_issue();

        repeat (4) @(posedge clock);
        check("pending_if", 32'(q_if.size()), 32'd0);
        check("pending_dm", 32'(q_dm.size()), 32'd0);
        check("pending_l1", 32'(q_a1.size()), 32'd0);
        check("pending_l4", 32'(q_a4.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
